alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 18 +
 rtl/alu_arbiter_alu.sv | 25 ++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: op-code constants and FSM state encoding shared by the arbiter and its ALU.
package alu_arbiter_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_MUL  = 3'b110,
    OP_PASS = 3'b111
  } op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU; add and multiply wrap modulo 2^WIDTH.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_ADD:  y = a + b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = WIDTH'(a < b);
      OP_MUL:  y = a * b;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter feeding two requesters into one shared ALU;
// one operation in flight, result held until the consumer accepts it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             busy,
  output logic [15:0]      done_cnt
);
  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]      done_cnt_q, done_cnt_d;
  logic [WIDTH-1:0] alu_y;
  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .y (alu_y)
  );
  // A lone valid bit is already one-hot, so it doubles as the grant.
  always_comb begin
    req_ready  = (rst_n && state_q == IDLE) ?
                 (req_valid == 2'b11 ? (ptr_q ? 2'b10 : 2'b01) : req_valid) : 2'b00;
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    done_cnt_d = done_cnt_q;
    if (|req_ready) begin
      state_d = EXEC;
      id_d    = req_ready[1];
      ptr_d   = ~req_ready[1];
      op_d    = req_ready[1] ? req_op1 : req_op0;
      a_d     = req_ready[1] ? req_a1 : req_a0;
      b_d     = req_ready[1] ? req_b1 : req_b0;
      cnt_d   = op_d == OP_MUL ? 4'(MUL_CYCLES - 1) : 4'd0;
    end
    if (state_q == EXEC) begin
      if (cnt_q == 4'd0) begin
        state_d    = RESP;
        rsp_data_d = alu_y;
        rsp_zero_d = alu_y == '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
    if (state_q == RESP && rsp_ready) begin
      state_d    = IDLE;
      done_cnt_d = done_cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      done_cnt_q <= done_cnt_d;
    end
  end
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors push expected responses into a queue; a monitor pops and compares on each response handshake.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [2:0]  req_op0 = '0, req_op1 = '0;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_zero, busy;
  logic [31:0] rsp_data;
  logic [15:0] done_cnt;
  typedef struct {logic id; logic [31:0] data; logic zero;} rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;
  int checks = 0, failures = 0, cyc = 0, acc = 0, exp_done = 0;
  alu_arbiter #(.WIDTH(32), .MUL_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy), .done_cnt(done_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot", 64'(req_ready == 2'b11), 64'd0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got id=%0d data=%0h expected no response", rsp_id, rsp_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
          chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
          chk("rsp_zero", 64'(rsp_zero), 64'(mon_e.zero));
          exp_done++;
        end
      end
    end
  end
  task automatic send(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] d);
    int k = 0;
    exp_q.push_back('{i[0], d, d == 32'd0});
    if (i == 0) begin
      req_op0 = op; req_a0 = a; req_b0 = b;
    end else begin
      req_op1 = op; req_a1 = a; req_b1 = b;
    end
    req_valid[i] = 1'b1;
    do begin @(negedge clk); k++; end while (!req_ready[i] && k < 20);
    chk("accept", 64'(req_ready[i]), 64'd1);
    @(posedge clk); #1;
    acc = cyc;
    req_valid[i] = 1'b0;
  endtask
  task automatic wait_rsp(input int lat, input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 30);
    chk(name, 64'(cyc - acc + 1), 64'(lat));
  endtask
  task automatic run_op(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input int lat, input string name);
    send(i, op, a, b, d);
    wait_rsp(lat, name);
    @(posedge clk); #1;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n;
    logic [15:0] dc;
    req_valid = 2'b01;
    #2;
    check_reset("rst");
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 3'b001, 32'd5, 32'd7, 32'd12, 2, "lat_add");
    run_op(0, 3'b101, 32'd3, 32'hFFFF_FFFF, 32'd1, 2, "lat_slt");
    run_op(1, 3'b000, 32'd9, 32'd9, 32'd0, 2, "lat_nop");
    run_op(1, 3'b110, 32'h1_0000, 32'h1_0000, 32'd0, 4, "lat_mul_wrap");
    run_op(0, 3'b110, 32'd3, 32'd5, 32'd15, 4, "lat_mul");
    run_op(1, 3'b010, 32'hF0F0, 32'hFF00, 32'hF000, 2, "lat_and");
    run_op(0, 3'b100, 32'hA5, 32'h5A, 32'hFF, 2, "lat_xor");
    run_op(1, 3'b001, 32'hFFFF_FFFF, 32'd1, 32'd0, 2, "lat_add_wrap");
    run_op(0, 3'b111, 32'hDEAD, 32'd1, 32'hDEAD, 2, "lat_pass");
    run_op(1, 3'b101, 32'd7, 32'd3, 32'd0, 2, "lat_slt_false");
    chk("done_cnt_10", 64'(done_cnt), 64'd10);
    rsp_ready = 1'b0;
    send(0, 3'b011, 32'hF0, 32'h0F, 32'hFF);
    wait_rsp(2, "lat_or");
    dc = done_cnt;
    exp_q.push_back('{1'b1, 32'h55, 1'b0});
    req_op1 = 3'b111; req_a1 = 32'h55; req_b1 = 32'h0;
    req_valid[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_data", 64'(rsp_data), 64'hFF);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_done_cnt", 64'(done_cnt), 64'(dc));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_done_inc", 64'(done_cnt), 64'(dc) + 64'd1);
    chk("stall_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    acc = cyc;
    req_valid[1] = 1'b0;
    wait_rsp(2, "lat_after_stall");
    @(posedge clk); #1;
    send(1, 3'b110, 32'd7, 32'd7, 32'd49);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_exec_rst");
    exp_q.delete();
    exp_done = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_rsp_after_rst", 64'(done_cnt), 64'd0);
    @(posedge clk); #1;
    exp_q.push_back('{1'b0, 32'd2, 1'b0});
    exp_q.push_back('{1'b1, 32'd0, 1'b1});
    exp_q.push_back('{1'b0, 32'd2, 1'b0});
    exp_q.push_back('{1'b1, 32'd0, 1'b1});
    req_op0 = 3'b001; req_a0 = 32'd1; req_b0 = 32'd1;
    req_op1 = 3'b100; req_a1 = 32'd3; req_b1 = 32'd3;
    req_valid = 2'b11;
    n = 0;
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        chk("grant_order", 64'(req_ready), (n % 2 == 1) ? 64'd2 : 64'd1);
        n++;
        if (n == 4) begin
          @(posedge clk); #1;
          req_valid = 2'b00;
        end
      end
    end
    chk("grant_count", 64'(n), 64'd4);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) @(negedge clk);
    @(posedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_cnt_rr", 64'(done_cnt), 64'(exp_done));
    chk("done_cnt_4", 64'(done_cnt), 64'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
